mult_div_unit: RTL
==================

Name: mult_div_unit

Overview:
- Multi-cycle multiply/divide unit that sits directly downstream of the ALU adder datapath.
- Consumes rs/rt operands from the execute stage and implements MIPS MULT, MULTU, DIV and DIVU with iterative shift-add/subtract.
- Results are held in the architectural HI/LO registers, which are read back for MFHI/MFLO and written directly by MTHI/MTLO.
- Handshake to the pipeline control is start/busy/done; the pipeline stalls on busy.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- CNT_W, 5, iteration counter width; must satisfy 2^CNT_W = WIDTH.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  begin an operation; sampled on a rising edge while IDLE.
- op  input  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- A  input  WIDTH  rs operand (multiplicand / dividend).
- B  input  WIDTH  rt operand (multiplier / divisor).
- hi_we  input  1  MTHI write enable.
- lo_we  input  1  MTLO write enable.
- wdata  input  WIDTH  MTHI/MTLO write data.
- busy  output  1  operation in progress.
- done  output  1  one-cycle pulse after HI/LO update.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.

Behaviour:
- Clocking and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values: hi=0, lo=0, busy=0, done=0, state=IDLE, counter=0, internal operand registers 0.

States and transitions:
- IDLE -> RUN on start=1 at an edge.
  - At that edge, latch op, A, B and the sign flags.
  - For signed ops, latch |A| and |B|. The magnitude of 0x80000000 is 2^31 as unsigned.
  - Clear the accumulator and counter.
- RUN, 32 edges:
  - Multiply: one shift-add step per edge (accumulator += multiplicand if multiplier LSB set, then shift right across a 64-bit product).
  - Divide: one restoring step per edge (shift remainder left with next dividend bit, trial subtract divisor, keep if non-negative, shift quotient bit in).
  - After the 32nd step, go to FIX.
- FIX, 1 edge:
  - Apply sign correction.
    - MULT: negate the 64-bit product if sign(A) XOR sign(B).
    - DIV: negate the quotient if signs differ; the remainder takes the sign of A.
  - Write HI/LO.
    - Multiply: HI = product[63:32], LO = product[31:0].
    - Divide: LO = quotient, HI = remainder.
  - Go to IDLE.
- busy=1 in RUN and FIX; busy=0 in IDLE. busy rises in the cycle after the start edge.

Latency and handshake:
- Start edge E0 -> HI/LO valid and done=1 in the cycle after edge E33.
- done is high for exactly one cycle, coincident with busy=0.
- start while busy=1 is ignored and the operation in flight continues unchanged.
- start=1 in the same cycle done=1 is accepted, because the state is IDLE.

Direct writes:
- hi_we/lo_we update the register with wdata at the edge, only when IDLE and start=0.
- hi_we/lo_we are ignored while busy or when start=1 in the same cycle (start wins).

Boundary conditions:
- Divide by zero (B=0): no exception and the same latency. HI=A (original, unsigned bits), LO=all ones.
- DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0 (natural wrap, no trap).
- Operands are sampled only at the start edge; later changes on A/B/op have no effect.
- rst_n low mid-operation aborts immediately. All outputs and state return to reset values and no done is produced.

Test Plan:
- MULTU A=0xFFFFFFFF, B=0xFFFFFFFF, start pulse -> busy=1 for 33 cycles; done one cycle; HI=0xFFFFFFFE, LO=0x00000001.
- MULT A=0xFFFFFFFD (-3), B=0x00000005 -> HI=0xFFFFFFFF, LO=0xFFFFFFF1. MULT A=0x80000000, B=0x80000000 -> HI=0x40000000, LO=0.
- DIV A=0xFFFFFFF9 (-7), B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU A=7, B=2 -> LO=3, HI=1. DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- DIVU A=0x64, B=0 -> after 33 cycles HI=0x00000064, LO=0xFFFFFFFF, done=1.
- Busy interactions: during a MULTU, pulse start with new operands and assert hi_we (wdata=0x1234) -> both ignored, result equals the first op. In IDLE, lo_we with wdata=0xABCD -> lo=0xABCD next cycle.
- Reset mid-op: DIVU started, rst_n low at cycle 10 -> busy, done, hi and lo go to 0 immediately, and no done pulse after release. A new start then completes normally.

Source files
------------

// File: rtl/mult_div_unit.sv
// Iterative MIPS multiply/divide unit owning the architectural HI/LO registers.
// One shift-add or restoring-divide step per cycle, then a sign-fix cycle.
module mult_div_unit #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             hi_we,
   input  logic             lo_we,
   input  logic [WIDTH-1:0] wdata,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_FIX  = 2'd2
   } state_t;

   state_t             r_state;
   state_t             w_state_nxt;
   logic [CNT_W-1:0]   r_cnt;
   logic               r_is_div;
   logic               r_sign_a;
   logic               r_sign_b;
   logic [WIDTH-1:0]   r_a_orig;
   logic [WIDTH-1:0]   r_m;
   logic [2*WIDTH-1:0] r_p;

   logic               w_neg_a;
   logic               w_neg_b;
   logic [WIDTH-1:0]   w_abs_a;
   logic [WIDTH-1:0]   w_abs_b;
   logic [WIDTH:0]     w_madd;
   logic [2*WIDTH-1:0] w_mul_nxt;
   logic               w_keep;
   logic [WIDTH-1:0]   w_rem_sub;
   logic [2*WIDTH-1:0] w_div_nxt;
   logic               w_sign_diff;
   logic [2*WIDTH-1:0] w_prod;
   logic [WIDTH-1:0]   w_quo;
   logic [WIDTH-1:0]   w_rem;
   logic               w_div_zero;

   // Two's-complement magnitude; the most negative value maps to 2^(WIDTH-1) unsigned.
   function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic neg);
      if (neg) begin
         mag = -v;
      end else begin
         mag = v;
      end
   endfunction

   // Operand magnitudes at the start edge
   always_comb begin
      w_neg_a = ~op[0] & A[WIDTH-1];
      w_neg_b = ~op[0] & B[WIDTH-1];
      w_abs_a = mag(A, w_neg_a);
      w_abs_b = mag(B, w_neg_b);
   end

   // Single iteration step for both multiply and divide
   always_comb begin
      if (r_p[0]) begin
         w_madd = {1'b0, r_p[2*WIDTH-1:WIDTH]} + {1'b0, r_m};
      end else begin
         w_madd = {1'b0, r_p[2*WIDTH-1:WIDTH]};
      end
      w_mul_nxt = {w_madd, r_p[WIDTH-1:1]};
      // Shifted remainder is WIDTH+1 bits; the kept difference always fits WIDTH bits.
      w_keep    = (r_p[2*WIDTH-1:WIDTH-1] >= {1'b0, r_m});
      w_rem_sub = r_p[2*WIDTH-2:WIDTH-1] - r_m;
      if (w_keep) begin
         w_div_nxt = {w_rem_sub, r_p[WIDTH-2:0], 1'b1};
      end else begin
         w_div_nxt = {r_p[2*WIDTH-2:0], 1'b0};
      end
   end

   // Sign correction applied in the fix cycle
   always_comb begin
      w_sign_diff = r_sign_a ^ r_sign_b;
      w_div_zero  = (r_m == {WIDTH{1'b0}});
      if (w_sign_diff) begin
         w_prod = -r_p;
         w_quo  = -r_p[WIDTH-1:0];
      end else begin
         w_prod = r_p;
         w_quo  = r_p[WIDTH-1:0];
      end
      if (r_sign_a) begin
         w_rem = -r_p[2*WIDTH-1:WIDTH];
      end else begin
         w_rem = r_p[2*WIDTH-1:WIDTH];
      end
   end

   // Next-state logic
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_state_nxt = S_RUN;
            end else begin
               w_state_nxt = S_IDLE;
            end
         end
         S_RUN: begin
            if (r_cnt == {CNT_W{1'b1}}) begin
               w_state_nxt = S_FIX;
            end else begin
               w_state_nxt = S_RUN;
            end
         end
         S_FIX:   w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Datapath, HI/LO and handshake outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt    <= {CNT_W{1'b0}};
         r_is_div <= 1'b0;
         r_sign_a <= 1'b0;
         r_sign_b <= 1'b0;
         r_a_orig <= {WIDTH{1'b0}};
         r_m      <= {WIDTH{1'b0}};
         r_p      <= {(2*WIDTH){1'b0}};
         hi       <= {WIDTH{1'b0}};
         lo       <= {WIDTH{1'b0}};
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         busy <= (w_state_nxt != S_IDLE);
         done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_cnt    <= {CNT_W{1'b0}};
                  r_is_div <= op[1];
                  r_sign_a <= w_neg_a;
                  r_sign_b <= w_neg_b;
                  r_a_orig <= A;
                  if (op[1]) begin
                     r_m <= w_abs_b;
                     r_p <= {{WIDTH{1'b0}}, w_abs_a};
                  end else begin
                     r_m <= w_abs_a;
                     r_p <= {{WIDTH{1'b0}}, w_abs_b};
                  end
               end else begin
                  if (hi_we) begin
                     hi <= wdata;
                  end
                  if (lo_we) begin
                     lo <= wdata;
                  end
               end
            end
            S_RUN: begin
               r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
               if (r_is_div) begin
                  r_p <= w_div_nxt;
               end else begin
                  r_p <= w_mul_nxt;
               end
            end
            S_FIX: begin
               done <= 1'b1;
               if (!r_is_div) begin
                  hi <= w_prod[2*WIDTH-1:WIDTH];
                  lo <= w_prod[WIDTH-1:0];
               end else if (w_div_zero) begin
                  hi <= r_a_orig;
                  lo <= {WIDTH{1'b1}};
               end else begin
                  hi <= w_rem;
                  lo <= w_quo;
               end
            end
            default: begin
               done <= 1'b0;
            end
         endcase
      end
   end

endmodule
